// File: rtl/heart_pkg.sv
// rtl/heart_pkg.sv - shared types and widths for the heart model
package heart_pkg;

  localparam int INTERVAL_W = 16;

  typedef enum logic {
    A_WAIT = 1'b0,
    V_WAIT = 1'b1
  } heart_state_t;

endpackage

// File: rtl/pace_edge_sync.sv
// rtl/pace_edge_sync.sv - two-flop synchronizer followed by a rising-edge pulse
module pace_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/heart_model.sv
// rtl/heart_model.sv - two-state intrinsic heart rhythm model producing AS/VS sense pulses
module heart_model
  import heart_pkg::*;
#(
  parameter int CYCLES_PER_MS = 100000,
  parameter int PULSE_CYCLES  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  AP,
  input  logic                  VP,
  input  logic [INTERVAL_W-1:0] va_ms,
  input  logic [INTERVAL_W-1:0] av_ms,
  output logic                  AS,
  output logic                  VS,
  output logic                  state
);

  localparam int PRE_W = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam int PLS_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES + 1) : 1;
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(CYCLES_PER_MS - 1);
  localparam logic [PLS_W-1:0]      PLS_LOAD = PLS_W'(PULSE_CYCLES - 1);
  // A transition cycle is itself elapsed cycle 0, so the next cycle resumes at 1
  localparam logic [PRE_W-1:0]      PRE_ONE  = (CYCLES_PER_MS > 1) ? PRE_W'(1) : '0;
  localparam logic [INTERVAL_W-1:0] MS_ONE   = (CYCLES_PER_MS > 1) ? '0 : INTERVAL_W'(1);

  heart_state_t          r_state;
  heart_state_t          w_next_state;
  logic                  r_entry;
  logic                  w_trans;
  logic                  w_expire;
  logic                  w_fire_as;
  logic                  w_fire_vs;
  logic                  w_ap_evt;
  logic                  w_vp_evt;
  logic [PRE_W-1:0]      r_pre;
  logic [INTERVAL_W-1:0] r_ms;
  logic [INTERVAL_W-1:0] r_interval;
  logic [INTERVAL_W-1:0] w_raw;
  logic [INTERVAL_W-1:0] w_sample;
  logic [PLS_W-1:0]      r_as_cnt;
  logic [PLS_W-1:0]      r_vs_cnt;
  logic                  r_as;
  logic                  r_vs;

  pace_edge_sync u_ap_sync (.i_clk(clk), .i_rst(rst), .i_async(AP), .o_rise(w_ap_evt));
  pace_edge_sync u_vp_sync (.i_clk(clk), .i_rst(rst), .i_async(VP), .o_rise(w_vp_evt));

  assign w_expire = !r_entry && (r_pre == '0) && (r_ms == r_interval);
  assign w_raw    = (w_next_state == A_WAIT) ? va_ms : av_ms;
  assign w_sample = (w_raw == '0) ? INTERVAL_W'(1) : w_raw;

  always_ff @(posedge clk) begin
    if (rst) r_state <= A_WAIT;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_trans      = 1'b0;
    if (!en) begin
      w_next_state = A_WAIT;
    end else if (w_vp_evt) begin
      w_next_state = A_WAIT;
      w_trans      = 1'b1;
    end else if (w_expire) begin
      w_next_state = (r_state == A_WAIT) ? V_WAIT : A_WAIT;
      w_trans      = 1'b1;
    end else if (w_ap_evt && (r_state == A_WAIT)) begin
      w_next_state = V_WAIT;
      w_trans      = 1'b1;
    end
  end

  always_comb begin
    w_fire_as = en && !w_vp_evt && w_expire && (r_state == A_WAIT);
    w_fire_vs = en && !w_vp_evt && w_expire && (r_state == V_WAIT);
  end

  // r_entry marks the first enabled cycle after reset or en=0, when va is sampled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry    <= 1'b1;
      r_pre      <= '0;
      r_ms       <= '0;
      r_interval <= '0;
    end else begin
      r_entry <= !en;
      if (en && (r_entry || w_trans)) r_interval <= w_sample;
      if (!en) begin
        r_pre <= '0;
        r_ms  <= '0;
      end else if (w_trans) begin
        r_pre <= PRE_ONE;
        r_ms  <= MS_ONE;
      end else if (r_pre == PRE_LAST) begin
        r_pre <= '0;
        if (r_ms != '1) r_ms <= r_ms + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_as     <= 1'b0;
      r_vs     <= 1'b0;
      r_as_cnt <= '0;
      r_vs_cnt <= '0;
    end else begin
      if (w_fire_as) begin
        r_as     <= 1'b1;
        r_as_cnt <= PLS_LOAD;
      end else if (r_as_cnt != '0) begin
        r_as_cnt <= r_as_cnt - 1'b1;
      end else begin
        r_as <= 1'b0;
      end
      if (w_fire_vs) begin
        r_vs     <= 1'b1;
        r_vs_cnt <= PLS_LOAD;
      end else if (r_vs_cnt != '0) begin
        r_vs_cnt <= r_vs_cnt - 1'b1;
      end else begin
        r_vs <= 1'b0;
      end
    end
  end

  assign AS    = r_as;
  assign VS    = r_vs;
  assign state = r_state;

endmodule

// File: tb/tb_heart_model.sv
// tb/tb_heart_model.sv - self-checking bench for heart_model with a cycle-count reference model
module tb_heart_model;

  localparam int C = 10;
  localparam int P = 3;

  logic        clk = 1'b0;
  logic        rst, en, AP, VP;
  logic [15:0] va_ms, av_ms;
  logic        AS, VS, state;

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: elapsed cycles since state entry against N*C
  int       m_state, m_k, m_n, as_fire, vs_fire;
  bit       m_fresh;
  bit [3:1] hap, hvp;
  bit       exp_as, exp_vs, exp_st;
  bit       as_seen, vs_seen;

  heart_model #(.CYCLES_PER_MS(C), .PULSE_CYCLES(P)) dut (
    .clk(clk), .rst(rst), .en(en), .AP(AP), .VP(VP),
    .va_ms(va_ms), .av_ms(av_ms), .AS(AS), .VS(VS), .state(state)
  );

  always #5 clk = ~clk;

  function automatic int san(input logic [15:0] v);
    return (v == 16'd0) ? 1 : int'(v);
  endfunction

  task automatic tick();
    bit ev_ap, ev_vp, expire, trans;
    int ns;
    ev_ap = hap[2] && !hap[3];
    ev_vp = hvp[2] && !hvp[3];
    if (rst) begin
      m_state = 0; m_k = 0; m_n = 0; m_fresh = 1;
      as_fire = -1000; vs_fire = -1000;
    end else if (!en) begin
      m_state = 0; m_k = 0; m_fresh = 1;
    end else begin
      if (m_fresh) m_n = san(va_ms);
      expire = (m_k == m_n * C);
      trans  = 0;
      ns     = m_state;
      if (ev_vp) begin
        trans = 1; ns = 0;
      end else if (expire) begin
        trans = 1; ns = 1 - m_state;
        if (m_state == 0) as_fire = cyc; else vs_fire = cyc;
      end else if (ev_ap && m_state == 0) begin
        trans = 1; ns = 1;
      end
      if (trans) begin
        m_state = ns;
        m_n     = san((ns == 0) ? va_ms : av_ms);
        m_k     = 1;
      end else begin
        m_k++;
      end
      m_fresh = 0;
    end
    hap = rst ? 3'b000 : {hap[2:1], AP};
    hvp = rst ? 3'b000 : {hvp[2:1], VP};
    @(posedge clk);
    #1;
    cyc++;
    exp_as = (cyc - as_fire >= 1) && (cyc - as_fire <= P);
    exp_vs = (cyc - vs_fire >= 1) && (cyc - vs_fire <= P);
    exp_st = (m_state == 1);
    if (AS === 1'b1) as_seen = 1;
    if (VS === 1'b1) vs_seen = 1;
  endtask

  task automatic wait_as(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (AS === 1'b1) begin at = cyc; break; end
      tick();
    end
  endtask

  task automatic wait_vs(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (VS === 1'b1) begin at = cyc; break; end
      tick();
    end
  endtask

  task automatic start_run(output int e);
    rst = 1; en = 1; AP = 0; VP = 0;
    tick();
    rst = 0;
    e = cyc;
    as_seen = 0; vs_seen = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; AP = 0; VP = 0; va_ms = 16'd5; av_ms = 16'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({AS, VS, state} !== 3'b000)
        $display("FAIL reset_outputs cyc=%0d got AS,VS,state=%b%b%b want 000", cyc, AS, VS, state);
      else n_pass++;
    end
  endtask

  task automatic test_free_run();
    int e, r1, v1, r2;
    va_ms = 16'd5; av_ms = 16'd2;
    start_run(e);
    wait_as(100, r1);
    n_checks++;
    if (r1 !== e + 51) $display("FAIL free_as_start got %0d want %0d", r1, e + 51); else n_pass++;
    n_checks++;
    if (state !== 1'b1) $display("FAIL free_state_v got %b want 1", state); else n_pass++;
    tick(); tick();
    n_checks++;
    if (AS !== 1'b1) $display("FAIL free_as_width3 got %b want 1", AS); else n_pass++;
    tick();
    n_checks++;
    if (AS !== 1'b0) $display("FAIL free_as_end got %b want 0", AS); else n_pass++;
    wait_vs(100, v1);
    n_checks++;
    if (v1 !== r1 + 20) $display("FAIL free_vs_start got %0d want %0d", v1, r1 + 20); else n_pass++;
    n_checks++;
    if (state !== 1'b0) $display("FAIL free_state_a got %b want 0", state); else n_pass++;
    wait_as(100, r2);
    n_checks++;
    if (r2 !== v1 + 50) $display("FAIL free_as_repeat got %0d want %0d", r2, v1 + 50); else n_pass++;
  endtask

  task automatic test_atrial_pace();
    int e, v;
    va_ms = 16'd5; av_ms = 16'd2;
    start_run(e);
    while (cyc < e + 18) tick();
    AP = 1;
    tick(); tick(); tick();
    n_checks++;
    if (state !== 1'b1) $display("FAIL ap_state got %b want 1", state); else n_pass++;
    AP = 0;
    wait_vs(100, v);
    n_checks++;
    if (v !== e + 41) $display("FAIL ap_vs_start got %0d want %0d", v, e + 41); else n_pass++;
    while (cyc < e + 60) tick();
    n_checks++;
    if (as_seen !== 1'b0) $display("FAIL ap_no_as got %b want 0", as_seen); else n_pass++;
  endtask

  task automatic test_vent_pace();
    int e, r;
    va_ms = 16'd5; av_ms = 16'd2;
    start_run(e);
    while (cyc < e + 58) tick();
    VP = 1;
    tick(); tick(); tick();
    n_checks++;
    if (state !== 1'b0) $display("FAIL vp_state got %b want 0", state); else n_pass++;
    VP = 0;
    wait_as(100, r);
    n_checks++;
    if (r !== e + 111) $display("FAIL vp_next_as got %0d want %0d", r, e + 111); else n_pass++;
    n_checks++;
    if (vs_seen !== 1'b0) $display("FAIL vp_no_vs got %b want 0", vs_seen); else n_pass++;
  endtask

  task automatic test_collision();
    int e, r;
    va_ms = 16'd5; av_ms = 16'd2;
    start_run(e);
    while (cyc < e + 48) tick();
    VP = 1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if ({AS, state} !== 2'b00) $display("FAIL coll_no_as got AS,state=%b%b want 00", AS, state); else n_pass++;
    VP = 0;
    wait_as(100, r);
    n_checks++;
    if (r !== e + 101) $display("FAIL coll_restart got %0d want %0d", r, e + 101); else n_pass++;
  endtask

  task automatic test_zero_interval();
    int e, r, v;
    va_ms = 16'd0; av_ms = 16'd0;
    start_run(e);
    wait_as(100, r);
    n_checks++;
    if (r !== e + 11) $display("FAIL zero_va got %0d want %0d", r, e + 11); else n_pass++;
    wait_vs(100, v);
    n_checks++;
    if (v !== e + 21) $display("FAIL zero_av got %0d want %0d", v, e + 21); else n_pass++;
  endtask

  task automatic test_reset_mid_pulse();
    int e, r, e2, r2;
    va_ms = 16'd5; av_ms = 16'd2;
    start_run(e);
    wait_as(100, r);
    tick();
    rst = 1;
    tick();
    n_checks++;
    if ({AS, state} !== 2'b00) $display("FAIL rstpulse_abort got AS,state=%b%b want 00", AS, state); else n_pass++;
    rst = 0;
    e2 = cyc;
    wait_as(100, r2);
    n_checks++;
    if (r2 !== e2 + 51) $display("FAIL rstpulse_restart got %0d want %0d", r2, e2 + 51); else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if (!en) en = ($urandom_range(0, 7) == 0);
      else if ($urandom_range(0, 299) == 0) en = 0;
      if ($urandom_range(0, 24) == 0) AP = ~AP;
      if ($urandom_range(0, 24) == 0) VP = ~VP;
      if ($urandom_range(0, 59) == 0) va_ms = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 59) == 0) av_ms = 16'($urandom_range(0, 4));
      tick();
      n_checks++;
      if ({AS, VS, state} !== {exp_as, exp_vs, exp_st}) begin
        errs++;
        if (errs <= 10)
          $display("FAIL rand_model cyc=%0d got AS,VS,state=%b%b%b want %b%b%b",
                   cyc, AS, VS, state, exp_as, exp_vs, exp_st);
      end else n_pass++;
    end
  endtask

  initial begin
    rst = 1; en = 0; AP = 0; VP = 0; va_ms = 16'd5; av_ms = 16'd2;
    hap = 3'b000; hvp = 3'b000;
    test_reset();
    test_free_run();
    test_atrial_pace();
    test_vent_pace();
    test_collision();
    test_zero_interval();
    test_reset_mid_pulse();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/heart_model.md
HEART_MODEL -- requirements
Module: heart_model

Interface
REQ-001 SHALL have parameter CYCLES_PER_MS, default 100000; clk cycles per 1 ms timing tick.
REQ-002 SHALL have parameter PULSE_CYCLES, default 10; high width of each AS/VS sense pulse, in cycles.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  model run enable.
REQ-006 SHALL have port AP  input  1  atrial pace request from the pacemaker GPIO; asynchronous level.
REQ-007 SHALL have port VP  input  1  ventricular pace request from the pacemaker GPIO; asynchronous level.
REQ-008 SHALL have port va_ms  input  16  intrinsic ventricular-to-atrial interval, in ms.
REQ-009 SHALL have port av_ms  input  16  atrioventricular conduction interval, in ms.
REQ-010 SHALL have port AS  output  1  atrial sense pulse, registered.
REQ-011 SHALL have port VS  output  1  ventricular sense pulse, registered.
REQ-012 SHALL have port state  output  1  current state: 0=A_WAIT, 1=V_WAIT.

Function
REQ-013 SHALL pass AP and VP each through a 2-flop synchronizer, then a rising-edge detect; each rise yields exactly one single-cycle pace event.
REQ-014 SHALL implement two states:
- A_WAIT: counting va_ms.
- V_WAIT: counting av_ms.
REQ-015 SHALL sample the interval input on the state-entry cycle and hold it for the whole wait; a sampled value of 0 SHALL be treated as 1.
REQ-016 SHALL clear the ms prescaler and the ms counter on every state entry; expiry SHALL occur exactly N*CYCLES_PER_MS cycles after entry, where N is the sampled interval.
REQ-017 A_WAIT transitions:
- va expiry -> fire AS, go to V_WAIT.
- AP event -> go to V_WAIT with no AS pulse.
- VP event -> re-enter A_WAIT and restart the va count.
REQ-018 V_WAIT transitions:
- av expiry -> fire VS, go to A_WAIT.
- VP event -> go to A_WAIT with no VS pulse.
- AP event -> ignored.
REQ-019 Same-cycle priority: VP event > interval expiry > AP event.
REQ-020 A fired pulse SHALL drive its output high starting the cycle after the trigger, for exactly PULSE_CYCLES cycles.
REQ-021 Re-triggering an output while its pulse is active SHALL restart the width count; AS and VS pulses are independent and may overlap.
REQ-022 While en=0:
- state forced to A_WAIT, counters cleared, pace events ignored.
- Active pulses complete normally.
REQ-023 After en rises, the first cycle with en=1 SHALL count as the A_WAIT entry cycle.
REQ-024 The ms counter SHALL be 16 bits and SHALL NOT wrap; expiry SHALL be detected by equality with the sampled interval.
REQ-025 The prescaler SHALL be wide enough for CYCLES_PER_MS-1, computed with $clog2.

Reset
REQ-026 Reset SHALL force:
- state=A_WAIT; AS=0, VS=0.
- prescaler, ms counter and pulse counters = 0.
- sampled intervals = 0.
- synchronizer and edge-detect flops = 0.
REQ-027 Reset SHALL take priority over en and over all events; asserting it mid-wait or mid-pulse SHALL abort both immediately.
REQ-028 After rst falls with en=1, the first non-reset cycle SHALL be the A_WAIT entry cycle.

Structure
REQ-029 Package heart_pkg SHALL hold:
- state enum (A_WAIT, V_WAIT).
- interval width constant (16).
REQ-030 A single sub-module, pace_edge_sync (2-flop synchronizer plus rising-edge pulse), SHALL be instantiated once for AP and once for VP.
REQ-031 Pulse stretching and timing SHALL remain in heart_model.

Verification (CYCLES_PER_MS=10, PULSE_CYCLES=3)
REQ-032 Free-run: en=1, va_ms=5, av_ms=2, no pacing -> AS high 3 cycles beginning 51 cycles after A_WAIT entry; VS high 3 cycles beginning 21 cycles after AS trigger; cycle repeats.
REQ-033 Atrial pace: AP rises 20 cycles into A_WAIT -> no AS; state=V_WAIT; VS fires 20 cycles after the V_WAIT entry.
REQ-034 Ventricular pace: VP rises during V_WAIT -> no VS; state=A_WAIT; next AS fires 50 cycles after that entry.
REQ-035 Collision: VP event on the same cycle as va expiry -> no AS; A_WAIT re-entered with the va count restarted.
REQ-036 Zero interval: av_ms=0 -> VS trigger 10 cycles after V_WAIT entry.
REQ-037 Reset mid-pulse: rst asserted during AS pulse cycle 2 -> AS=0 and state=0 on the next cycle; with en=1, AS fires 50 cycles after rst falls.
